pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard and forwarding unit for the pipelined CPU's decode stage. It tracks in-flight register writes internally in a DEPTH-entry shift register, so it needs no per-stage wreg/rn/m2reg inputs. From that state it generates the rs/rt forwarding selects and the load-use `nostall`. Beyond the fixed EXE/MEM forwarder it adds per-instruction result-ready stage, pipeline-wide hold, branch kill, and a stall counter.

## Interface
- DEPTH, 3, number of post-ID stages tracked (1=EXE … DEPTH=WB); legal range 2..7
- AW, 5, register-number width (NREG = 2**AW)
- FW, $clog2(DEPTH+1), width of forwarding selects
- SCW, 16, stall-counter width
- clock  in  1  rising-edge clock
- resetn  in  1  reset; asynchronous, active-low
- hold  in  1  freezes the whole tracked pipeline (e.g. memory wait)
- kill  in  1  squashes the instruction currently in ID (taken branch/jump)
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  AW  source register numbers
- id_use_rs, id_use_rt  in  1  source actually read
- id_wreg  in  1  instruction writes a register
- id_rn  in  AW  destination register
- id_rdy  in  FW  first stage whose output carries the result (ALU=1, load=2); 0 treated as 1, >DEPTH treated as DEPTH
- nostall  out  1  ID may advance
- fwda, fwdb  out  FW  0 = register file, p = stage-p result
- wb_valid  out  1  entry at position DEPTH is a write
- wb_rn  out  AW  its destination
- stall_cnt  out  SCW  saturating count of stall cycles

## Operation
- State: entry[1..DEPTH], each holding {v, rn, rdy}. Reset: all v=0, rn=0, rdy=0; stall_cnt=0.
- Reset outputs: nostall=1, fwda=fwdb=0, wb_valid=0, wb_rn=0.
- Match for source r: the valid entry with rn==r and the lowest position p.
- No forwarding or stall is generated when r==0 or the source is unused.
- If no match: fwd=0.
- If a match exists and p >= entry.rdy: fwd=p.
- If a match exists and p < entry.rdy: the source is not ready; fwd=0.
- Only the nearest match is considered; an older ready copy never bypasses a younger unready one.
- nostall = ~(id_valid & ~kill & (rs not ready | rt not ready)).
- Issue fires when id_valid & ~kill & nostall & ~hold.
- On issue, entry[1] <= {id_wreg & (id_rn!=0), id_rn, clamped id_rdy}.
- Without issue and with ~hold, entry[1] <= bubble (v=0).
- With ~hold, entry[p] <= entry[p-1] for p=2..DEPTH; entry[DEPTH] retires.
- hold=1: no entry changes, stall_cnt does not change, and outputs keep being computed from the frozen state. hold has priority over issue and kill.
- stall_cnt increments on each ~hold cycle with id_valid & ~kill & ~nostall, saturating at all-ones.
- wb_valid/wb_rn = entry[DEPTH].v / .rn, for scoreboard checking against register-file writes.

## Timing
- nostall, fwda, fwdb and wb_* are combinational from current state plus ID inputs; no input-to-state latency beyond one edge.
- An issued instruction sits at position p exactly p edges after issue, with hold cycles not counted.
- Back-to-back ALU dependency: zero stall, fwd=1.
- Load-use with rdy=2: exactly one stall cycle, then fwd=2.
- rdy=k dependency issued directly behind: k-1 stall cycles.
- Same-cycle write at position DEPTH and read in ID: fwd=DEPTH. The unit does not rely on register-file write-through.
- kill together with a stall condition: nostall=1, no count, bubble inserted.
- resetn low mid-operation clears all entries and stall_cnt immediately, without waiting for a clock edge.

## Structure
- Package pipe_hazard_pkg holds:
  - DEPTH/AW defaults;
  - select constants FWD_RF=0, FWD_EXE=1, FWD_MEM=2, FWD_WB=3;
  - the entry struct {v, rn, rdy}.
- Sub-module pipe_src_match: combinational nearest-match priority search over the entries, producing {hit, p, ready}. It is instantiated twice, once for rs and once for rt.
- Top level holds the shift register, issue/bubble logic and the counter.

## Test plan
- ALU dependency: issue add r3 (rdy=1), then id_rs=3 next cycle -> fwda=1, nostall=1.
  - The second cycle after issue gives fwda=2.
  - The third gives fwda=3.
  - The fourth gives fwda=0.
- Load-use: issue lw r3 (rdy=2), then id_rt=3 -> nostall=0 for one cycle and stall_cnt=1; the next cycle gives fwdb=2 and nostall=1.
- r0 and unused sources:
  - Writer with id_rn=0 -> entry v=0; a later id_rs=0 gives fwda=0 and nostall=1.
  - Matching rs with id_use_rs=0 -> fwda=0 and no stall.
- Nearest copy: r5 written at positions 1 (rdy=2) and 2 (rdy=1) -> stall, fwda not 2; the next cycle gives fwda=2 from the younger writer.
- Hold: lw r3 in EXE, dependent in ID, hold=1 for 3 cycles -> entries frozen, nostall=0 and stall_cnt=0 throughout; after release, one stall cycle is counted, then fwd=2.
- Kill and reset:
  - kill while stalled -> nostall=1, stall_cnt unchanged, entry[1].v=0.
  - resetn pulsed low with all entries valid -> wb_valid=0, stall_cnt=0, fwda=fwdb=0.
  - stall_cnt driven to 0xFFFF stays 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the decode-stage hazard/forwarding unit.
package pipe_hazard_pkg;

  localparam int DEPTH_DEF = 3;
  localparam int AW_DEF    = 5;

  // Entry field widths are fixed so one struct serves every legal parameter set.
  localparam int AW_MAX = 8;
  localparam int RDY_W  = 3;

  localparam int FWD_RF  = 0;
  localparam int FWD_EXE = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

  typedef struct packed {
    logic              v;
    logic [AW_MAX-1:0] rn;
    logic [RDY_W-1:0]  rdy;
  } entry_t;

endpackage

// File: rtl/pipe_src_match.sv
// Nearest-match priority search for one source register over the in-flight writes.
module pipe_src_match
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int FW    = $clog2(DEPTH + 1)
) (
  input  entry_t          ents [DEPTH],
  input  logic [AW-1:0]   src,
  input  logic            used,
  output logic            hit,
  output logic [FW-1:0]   p,
  output logic            ready
);

  logic [RDY_W-1:0] rdy_near;

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit      = 1'b0;
    p        = '0;
    rdy_near = '0;
    if (used && src != '0) begin
      // Scan oldest to youngest so the lowest position wins.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (ents[i].v && ents[i].rn == AW_MAX'(src)) begin
          hit      = 1'b1;
          p        = FW'(i + 1);
          rdy_near = ents[i].rdy;
        end
      end
    end
    ready = !hit || (RDY_W'(p) >= rdy_near);
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard unit: tracks in-flight writes, drives forwarding selects and load-use stall.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int FW    = $clog2(DEPTH + 1),
  parameter int SCW   = 16
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           hold,
  input  logic           kill,
  input  logic           id_valid,
  input  logic [AW-1:0]  id_rs,
  input  logic [AW-1:0]  id_rt,
  input  logic           id_use_rs,
  input  logic           id_use_rt,
  input  logic           id_wreg,
  input  logic [AW-1:0]  id_rn,
  input  logic [FW-1:0]  id_rdy,
  output logic           nostall,
  output logic [FW-1:0]  fwda,
  output logic [FW-1:0]  fwdb,
  output logic           wb_valid,
  output logic [AW-1:0]  wb_rn,
  output logic [SCW-1:0] stall_cnt
);

  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  entry_t        ents [DEPTH];
  entry_t        new_ent;
  logic [FW-1:0] rdy_clamped;
  logic          hit_a, hit_b, ready_a, ready_b;
  logic [FW-1:0] p_a, p_b;
  logic          stall_now, issue;

  pipe_src_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_match_rs (
    .ents(ents), .src(id_rs), .used(id_use_rs),
    .hit(hit_a), .p(p_a), .ready(ready_a)
  );

  pipe_src_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_match_rt (
    .ents(ents), .src(id_rt), .used(id_use_rt),
    .hit(hit_b), .p(p_b), .ready(ready_b)
  );

  always_comb begin
    rdy_clamped = id_rdy;
    if (id_rdy == '0)
      rdy_clamped = FW'(FWD_EXE);
    else if (id_rdy > DEPTH_F)
      rdy_clamped = DEPTH_F;
  end

  always_comb begin
    new_ent     = '0;
    new_ent.v   = id_wreg && (id_rn != '0);
    new_ent.rn  = AW_MAX'(id_rn);
    new_ent.rdy = RDY_W'(rdy_clamped);
  end

  // A killed instruction never stalls; it is replaced by a bubble instead.
  assign stall_now = id_valid && !kill && !(ready_a && ready_b);
  assign issue     = id_valid && !kill && !stall_now && !hold;

  assign nostall  = !stall_now;
  assign fwda     = (hit_a && ready_a) ? p_a : FW'(FWD_RF);
  assign fwdb     = (hit_b && ready_b) ? p_b : FW'(FWD_RF);
  assign wb_valid = ents[DEPTH-1].v;
  assign wb_rn    = ents[DEPTH-1].rn[AW-1:0];

  // NOTE: the entry array is small and its valid bits gate forwarding, so it is reset
  // like any other state; large data memories would normally be left unreset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
    end else if (!hold) begin
      ents[0] <= issue ? new_ent : '0;
      for (int i = 1; i < DEPTH; i++) ents[i] <= ents[i-1];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      stall_cnt <= '0;
    else if (!hold && stall_now && stall_cnt != '1)
      stall_cnt <= stall_cnt + SCW'(1);
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: age-based reference model, directed scenarios plus random traffic.
module tb_pipe_hazard_unit;

  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int FW    = 2;
  localparam int SCW   = 6;
  localparam int CNT_MAX = (1 << SCW) - 1;

  logic           clock  = 1'b0;
  logic           resetn = 1'b0;
  logic           hold = 1'b0, kill = 1'b0, id_valid = 1'b0;
  logic [AW-1:0]  id_rs = '0, id_rt = '0, id_rn = '0;
  logic           id_use_rs = 1'b0, id_use_rt = 1'b0, id_wreg = 1'b0;
  logic [FW-1:0]  id_rdy = '0;
  logic           nostall, wb_valid;
  logic [FW-1:0]  fwda, fwdb;
  logic [AW-1:0]  wb_rn;
  logic [SCW-1:0] stall_cnt;

  pipe_hazard_unit #(.DEPTH(DEPTH), .AW(AW), .FW(FW), .SCW(SCW)) dut (
    .clock(clock), .resetn(resetn), .hold(hold), .kill(kill),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_rn(id_rn), .id_rdy(id_rdy),
    .nostall(nostall), .fwda(fwda), .fwdb(fwdb),
    .wb_valid(wb_valid), .wb_rn(wb_rn), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: every issued instruction with its age (edges since issue, holds excluded).
  typedef struct {
    bit wr;
    int rn;
    int rdy;
    int age;
  } inst_t;

  typedef struct {
    bit nostall;
    int fwda;
    int fwdb;
    bit wbv;
    int wbrn;
    int cnt;
  } exp_t;

  inst_t flight[$];
  exp_t  exp_q[$];
  int    cnt_model = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void src_look(input int r, input bit used, output int fwd, output bit ready);
    int best;
    best  = -1;
    fwd   = 0;
    ready = 1'b1;
    if (!used || r == 0) return;
    foreach (flight[i])
      if (flight[i].wr && flight[i].rn == r && flight[i].age >= 1 && flight[i].age <= DEPTH &&
          (best < 0 || flight[i].age < flight[best].age))
        best = i;
    if (best < 0) return;
    if (flight[best].age >= flight[best].rdy) fwd = flight[best].age;
    else ready = 1'b0;
  endfunction

  // Predict this cycle's outputs from the current model, then advance the model over the next edge.
  task automatic eval_cycle(input bit in_reset);
    exp_t e;
    int   fa, fb, rdy;
    bit   ra, rb, stall;
    src_look(int'(id_rs), id_use_rs, fa, ra);
    src_look(int'(id_rt), id_use_rt, fb, rb);
    stall     = id_valid && !kill && !(ra && rb);
    e.nostall = !stall;
    e.fwda    = fa;
    e.fwdb    = fb;
    e.wbv     = 1'b0;
    e.wbrn    = 0;
    foreach (flight[i])
      if (flight[i].age == DEPTH && flight[i].wr) begin
        e.wbv  = 1'b1;
        e.wbrn = flight[i].rn;
      end
    e.cnt = cnt_model;
    exp_q.push_back(e);
    if (in_reset || hold) return;
    foreach (flight[i]) flight[i].age++;
    for (int i = flight.size() - 1; i >= 0; i--)
      if (flight[i].age > DEPTH) flight.delete(i);
    if (id_valid && !kill && !stall) begin
      rdy = int'(id_rdy);
      if (rdy == 0) rdy = 1;
      if (rdy > DEPTH) rdy = DEPTH;
      flight.push_back('{wr: id_wreg && id_rn != 0, rn: int'(id_rn), rdy: rdy, age: 1});
    end
    if (stall && cnt_model < CNT_MAX) cnt_model++;
  endtask

  task automatic drive(input bit v, input bit k, input bit h,
                       input int rs, input int rt, input bit urs, input bit urt,
                       input bit wr, input int rn, input int rdy);
    @(posedge clock);
    #1;
    resetn    = 1'b1;
    id_valid  = v;
    kill      = k;
    hold      = h;
    id_rs     = AW'(rs);
    id_rt     = AW'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_wreg   = wr;
    id_rn     = AW'(rn);
    id_rdy    = FW'(rdy);
    eval_cycle(1'b0);
  endtask

  task automatic reset_pulse();
    @(posedge clock);
    #1;
    resetn = 1'b0;
    flight.delete();
    cnt_model = 0;
    eval_cycle(1'b1);
  endtask

  // Monitor: compares the DUT against the oldest pending prediction, away from the rising edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("nostall", int'(nostall), int'(e.nostall));
      check("fwda", int'(fwda), e.fwda);
      check("fwdb", int'(fwdb), e.fwdb);
      check("wb_valid", int'(wb_valid), int'(e.wbv));
      if (e.wbv) check("wb_rn", int'(wb_rn), e.wbrn);
      check("stall_cnt", int'(stall_cnt), e.cnt);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_pulse();
    reset_pulse();

    // ALU dependency: forward from EXE, MEM, WB, then register file.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 3, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 3, 0, 1, 0, 0, 0, 1);

    // Load-use: one stall, then forward from MEM.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 3, 2);
    drive(1, 0, 0, 0, 3, 0, 1, 1, 4, 1);
    drive(1, 0, 0, 0, 3, 0, 1, 1, 4, 1);

    // r0 writer and unused source.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 6, 2);
    drive(1, 0, 0, 6, 0, 0, 0, 0, 0, 1);

    // Nearest copy: younger unready writer masks an older ready one.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5, 2);
    drive(1, 0, 0, 5, 0, 1, 0, 0, 0, 1);
    drive(1, 0, 0, 5, 0, 1, 0, 0, 0, 1);

    // Hold with a pending load-use.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 3, 2);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 3, 0, 1, 0, 0, 0, 1);
    drive(1, 0, 0, 3, 0, 1, 0, 0, 0, 1);
    drive(1, 0, 0, 3, 0, 1, 0, 0, 0, 1);

    // Kill while stalled, then the same dependent without kill.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 7, 3);
    drive(1, 1, 0, 7, 0, 1, 0, 1, 8, 1);
    drive(1, 0, 0, 7, 0, 1, 0, 1, 8, 1);
    drive(0, 0, 0, 7, 0, 1, 0, 0, 0, 1);

    // Fill all entries, then reset asynchronously mid-cycle.
    for (int i = 1; i <= DEPTH; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, i + 8, 1);
    reset_pulse();
    drive(0, 0, 0, 9, 10, 1, 1, 0, 0, 1);

    // Repeated self-dependent slow writers drive the stall counter into saturation.
    for (int i = 0; i < 110; i++) drive(1, 0, 0, 3, 0, 1, 0, 1, 3, 3);

    // Randomized traffic over a small register range to provoke hazards.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(99) == 0) begin
        reset_pulse();
      end else begin
        drive($urandom_range(9) < 8, $urandom_range(9) == 0, $urandom_range(9) == 0,
              int'($urandom_range(7)), int'($urandom_range(7)),
              $urandom_range(9) != 0, $urandom_range(9) != 0,
              $urandom_range(9) < 8, int'($urandom_range(7)), int'($urandom_range(3)));
      end
    end

    @(negedge clock);
    #1;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
